// File: rtl/morse_game_pkg.sv
// Shared types, constants and helpers for the Morse guessing game.
// MORSE_HEX_DIGITS_EN selects 0..14 digits; default folds them to 0..9.
package morse_game_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHOW,
      ANSWER,
      RESULT
   } state_t;

   localparam logic [3:0] LFSR_SEED = 4'b0001;
   localparam int         LFSR_TAP_HI = 3;
   localparam int         LFSR_TAP_LO = 2;

   localparam int DISPLAY_CYCLES_DEF = 16;
   localparam int ANSWER_CYCLES_DEF  = 32;
   localparam int ROUNDS_DEF         = 8;

   function automatic logic [3:0] lfsr_next(input logic [3:0] v);
      return {v[2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
   endfunction

   // LFSR never holds zero, so value-1 always lands in 0..14.
   function automatic logic [3:0] lfsr_to_digit(input logic [3:0] v);
      logic [3:0] d;
      d = v - 4'd1;
`ifdef MORSE_HEX_DIGITS_EN
      return d;
`else
      return (d >= 4'd10) ? d - 4'd10 : d;
`endif
   endfunction

endpackage

// File: rtl/morse_lfsr4.sv
// 4-bit Fibonacci LFSR (shift left, feedback b3^b2) that advances only on step.
module morse_lfsr4
   import morse_game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   output logic [3:0] value
);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst)
         value <= LFSR_SEED;
      else if (step)
         value <= lfsr_next(value);
   end

endmodule

// File: rtl/morse_round_ctrl.sv
// Round controller for the Morse guessing game: show a digit, collect a guess, score it.
// Build option: MORSE_HEX_DIGITS_EN (digit range, see morse_game_pkg).
module morse_round_ctrl
   import morse_game_pkg::*;
#(
   parameter int DISPLAY_CYCLES = DISPLAY_CYCLES_DEF,
   parameter int ANSWER_CYCLES  = ANSWER_CYCLES_DEF,
   parameter int ROUNDS         = ROUNDS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       logout,
   input  logic       guess_valid,
   input  logic [3:0] guess,
   output logic [3:0] number,
   output logic       timeout,
   output logic       logout_from_gamecontrol,
   output logic [3:0] score,
   output logic       round_done,
   output logic       correct,
   output logic       game_over,
   output logic       busy
);

   localparam int CNT_MAX = (DISPLAY_CYCLES > ANSWER_CYCLES) ? DISPLAY_CYCLES : ANSWER_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] SHOW_LAST = CW'(DISPLAY_CYCLES - 1);
   localparam logic [CW-1:0] ANS_LAST  = CW'(ANSWER_CYCLES - 1);

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic [3:0]    rnd_cnt;
   logic [3:0]    lfsr_value;
   logic          enter_show;
   logic          start_game;
   logic          take_guess;
   logic          do_logout;
   logic          hit;

   morse_lfsr4 u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .step  (enter_show),
      .value (lfsr_value)
   );

   assign hit = take_guess && (guess == number);

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt  = state;
      enter_show = 1'b0;
      start_game = 1'b0;
      take_guess = 1'b0;
      do_logout  = 1'b0;
      if (logout && state != IDLE) begin
         state_nxt = IDLE;
         do_logout = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state_nxt  = SHOW;
                  enter_show = 1'b1;
                  start_game = 1'b1;
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST)
                  state_nxt = ANSWER;
            end
            ANSWER: begin
               if (guess_valid) begin
                  state_nxt  = RESULT;
                  take_guess = 1'b1;
               end else if (cnt == ANS_LAST) begin
                  state_nxt = RESULT;
               end
            end
            RESULT: begin
               if (rnd_cnt < 4'(ROUNDS)) begin
                  state_nxt  = SHOW;
                  enter_show = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                   <= IDLE;
         cnt                     <= '0;
         rnd_cnt                 <= '0;
         number                  <= '0;
         timeout                 <= 1'b1;
         score                   <= '0;
         round_done              <= 1'b0;
         correct                 <= 1'b0;
         game_over               <= 1'b0;
         busy                    <= 1'b0;
         logout_from_gamecontrol <= 1'b0;
      end else begin
         state                   <= state_nxt;
         cnt                     <= (state_nxt != state) ? '0 : cnt + CW'(1);
         timeout                 <= (state_nxt != SHOW);
         busy                    <= (state_nxt != IDLE);
         round_done              <= (state_nxt == RESULT);
         game_over               <= (state_nxt == RESULT) && (rnd_cnt == 4'(ROUNDS - 1));
         logout_from_gamecontrol <= do_logout;

         if (enter_show)
            number <= lfsr_to_digit(lfsr_next(lfsr_value));

         if (start_game) begin
            score   <= '0;
            rnd_cnt <= '0;
         end else if (state_nxt == RESULT) begin
            rnd_cnt <= rnd_cnt + 4'd1;
            correct <= hit;
            if (hit && score != 4'd15)
               score <= score + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_morse_round_ctrl.sv
// Table-driven bench for morse_round_ctrl (ROUNDS=3): one row per round across three games.
module tb_morse_round_ctrl;

   typedef enum logic [1:0] {K_GUESS, K_NONE, K_LOGOUT} kind_t;

   typedef struct {
      kind_t      kind;
      logic [3:0] guess;
      int         delay;
      logic [3:0] num;
      logic       corr;
      logic [3:0] score;
      logic       go;
   } row_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       logout = 1'b0;
   logic       guess_valid = 1'b0;
   logic [3:0] guess = 4'd0;
   logic [3:0] number;
   logic       timeout;
   logic       logout_from_gamecontrol;
   logic [3:0] score;
   logic       round_done;
   logic       correct;
   logic       game_over;
   logic       busy;

   int checks = 0;
   int errors = 0;
   row_t tbl[9];

   morse_round_ctrl #(
      .DISPLAY_CYCLES (16),
      .ANSWER_CYCLES  (32),
      .ROUNDS         (3)
   ) dut (
      .clk                     (clk),
      .rst                     (rst),
      .start                   (start),
      .logout                  (logout),
      .guess_valid             (guess_valid),
      .guess                   (guess),
      .number                  (number),
      .timeout                 (timeout),
      .logout_from_gamecontrol (logout_from_gamecontrol),
      .score                   (score),
      .round_done              (round_done),
      .correct                 (correct),
      .game_over               (game_over),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      int n;

      // LFSR 0010,0100,1001,0011,0110,1101,1010,0101,1011 -> digits value-1 (>=10 folded).
      tbl[0] = '{K_GUESS,  4'd1, 0,  4'd1, 1'b1, 4'd1, 1'b0};
      tbl[1] = '{K_NONE,   4'd0, 0,  4'd3, 1'b0, 4'd1, 1'b0};
      tbl[2] = '{K_GUESS,  4'd8, 31, 4'd8, 1'b1, 4'd2, 1'b1};
      tbl[3] = '{K_GUESS,  4'd2, 5,  4'd2, 1'b1, 4'd1, 1'b0};
      tbl[4] = '{K_GUESS,  4'd5, 0,  4'd5, 1'b1, 4'd2, 1'b0};
`ifdef MORSE_HEX_DIGITS_EN
      tbl[5] = '{K_GUESS,  4'd12, 10, 4'd12, 1'b1, 4'd3, 1'b1};
`else
      tbl[5] = '{K_GUESS,  4'd2, 10, 4'd2, 1'b1, 4'd3, 1'b1};
`endif
      tbl[6] = '{K_GUESS,  4'd9, 3,  4'd9, 1'b1, 4'd1, 1'b0};
      tbl[7] = '{K_GUESS,  4'd7, 0,  4'd4, 1'b0, 4'd1, 1'b0};
`ifdef MORSE_HEX_DIGITS_EN
      tbl[8] = '{K_LOGOUT, 4'd0, 4,  4'd10, 1'b0, 4'd1, 1'b0};
`else
      tbl[8] = '{K_LOGOUT, 4'd0, 4,  4'd0, 1'b0, 4'd1, 1'b0};
`endif

      step();
      step();
      rst = 1'b0;
      check("reset number", number, 0);
      check("reset timeout", timeout, 1);
      check("reset busy", busy, 0);
      check("reset score", score, 0);
      check("reset round_done", round_done, 0);
      check("reset correct", correct, 0);
      check("reset game_over", game_over, 0);
      check("reset logout_ack", logout_from_gamecontrol, 0);

      for (int i = 0; i < 9; i++) begin
         if (i == 0 || tbl[i-1].go) begin
            if (i > 0) begin
               logout = 1'b1;
               step();
               logout = 1'b0;
               check($sformatf("r%0d idle logout ack", i), logout_from_gamecontrol, 0);
               check($sformatf("r%0d idle logout busy", i), busy, 0);
            end
            start = 1'b1;
            step();
            start = 1'b0;
         end else begin
            step();
         end
         check($sformatf("r%0d number", i), number, tbl[i].num);
         check($sformatf("r%0d show busy", i), busy, 1);
         check($sformatf("r%0d show round_done", i), round_done, 0);

         // start and guess_valid held through SHOW must both be ignored.
         n = 0;
         while (timeout == 1'b0 && n < 100) begin
            start       = 1'b1;
            guess_valid = 1'b1;
            guess       = tbl[i].num;
            n++;
            step();
         end
         start       = 1'b0;
         guess_valid = 1'b0;
         check($sformatf("r%0d show cycles", i), n, 16);

         case (tbl[i].kind)
            K_GUESS: begin
               repeat (tbl[i].delay) step();
               guess_valid = 1'b1;
               guess       = tbl[i].guess;
               step();
               guess_valid = 1'b0;
            end
            K_NONE: begin
               n = 0;
               while (round_done == 1'b0 && n < 100) begin
                  step();
                  n++;
               end
               check($sformatf("r%0d answer timeout cycles", i), n, 32);
            end
            default: begin
               repeat (tbl[i].delay) step();
               logout      = 1'b1;
               guess_valid = 1'b1;
               guess       = tbl[i].num;
               step();
               logout      = 1'b0;
               guess_valid = 1'b0;
               check($sformatf("r%0d logout ack", i), logout_from_gamecontrol, 1);
               check($sformatf("r%0d logout busy", i), busy, 0);
               check($sformatf("r%0d logout timeout", i), timeout, 1);
               check($sformatf("r%0d logout round_done", i), round_done, 0);
               check($sformatf("r%0d logout score", i), score, tbl[i].score);
               step();
               check($sformatf("r%0d logout ack one cycle", i), logout_from_gamecontrol, 0);
               check($sformatf("r%0d logout stays idle", i), busy, 0);
            end
         endcase

         if (tbl[i].kind != K_LOGOUT) begin
            check($sformatf("r%0d round_done", i), round_done, 1);
            check($sformatf("r%0d correct", i), correct, tbl[i].corr);
            check($sformatf("r%0d score", i), score, tbl[i].score);
            check($sformatf("r%0d game_over", i), game_over, tbl[i].go);
            check($sformatf("r%0d result timeout", i), timeout, 1);
            if (tbl[i].go) begin
               step();
               check($sformatf("r%0d end busy", i), busy, 0);
               check($sformatf("r%0d end game_over pulse", i), game_over, 0);
               check($sformatf("r%0d end round_done pulse", i), round_done, 0);
            end
         end
      end

      // Reset mid-game together with logout: no pulse outputs, LFSR back to seed.
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (3) step();
      rst    = 1'b1;
      logout = 1'b1;
      step();
      rst    = 1'b0;
      logout = 1'b0;
      check("midrst busy", busy, 0);
      check("midrst timeout", timeout, 1);
      check("midrst number", number, 0);
      check("midrst score", score, 0);
      check("midrst logout_ack", logout_from_gamecontrol, 0);
      check("midrst round_done", round_done, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      check("post-reset number", number, 1);
      check("post-reset busy", busy, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
